// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler: spawns obstacles into lanes, scrolls them left
// each frame tick, and paces spawns with an LFSR-driven cooldown.
module obstacle_scheduler #(
    parameter int NSLOT         = 4,
    parameter int CORDW         = 10,
    parameter int X_SPAWN       = 750,
    parameter int X_MIN         = 170,
    parameter int SPEED0        = 2,
    parameter int MAX_SPEED     = 8,
    parameter int MIN_GAP       = 40,
    parameter int GAP_MASK      = 63,
    parameter int SPEEDUP_EVERY = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   tick,
    input  logic                   run,
    input  logic                   collide,
    input  logic                   restart,
    output logic [NSLOT-1:0]       obs_valid,
    output logic [NSLOT*CORDW-1:0] obs_x,
    output logic [2*NSLOT-1:0]     obs_lane,
    output logic [3:0]             speed,
    output logic [1:0]             sched_state
);

    localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [NSLOT-1:0] valid_q, valid_n;
    logic [CORDW-1:0] x_q    [NSLOT];
    logic [CORDW-1:0] x_n    [NSLOT];
    logic [1:0]       lane_q [NSLOT];
    logic [1:0]       lane_n [NSLOT];
    logic [3:0]       speed_q, speed_n;
    logic [7:0]       cool_q, cool_n;
    logic [7:0]       cnt_q, cnt_n;
    logic [15:0]      lfsr_q, lfsr_n;
    logic [7:0]       reload;
    logic [CORDW:0]   lim;
    logic             free_any;
    logic [IW-1:0]    free_idx;

    assign reload = 8'(MIN_GAP) + (lfsr_q[9:2] & 8'(GAP_MASK));
    assign lim    = (CORDW+1)'(X_MIN) + (CORDW+1)'(speed_q);

    // Lowest-index slot that was free before this tick.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_n = state_q;
        valid_n = valid_q;
        x_n     = x_q;
        lane_n  = lane_q;
        speed_n = speed_q;
        cool_n  = cool_q;
        cnt_n   = cnt_q;
        lfsr_n  = lfsr_q;
        unique case (state_q)
            IDLE: begin
                valid_n = '0;
                for (int i = 0; i < NSLOT; i++) begin
                    x_n[i]    = '0;
                    lane_n[i] = '0;
                end
                speed_n = 4'(SPEED0);
                cool_n  = 8'(MIN_GAP);
                cnt_n   = '0;
                if (run) state_n = RUN;
            end
            RUN: begin
                if (!run) begin
                    state_n = IDLE;
                end else if (collide) begin
                    state_n = HALT;
                end else if (tick) begin
                    lfsr_n = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                              lfsr_q[15:1]};
                    for (int i = 0; i < NSLOT; i++) begin
                        if (valid_q[i]) begin
                            if ({1'b0, x_q[i]} < lim) valid_n[i] = 1'b0;
                            else x_n[i] = x_q[i] - CORDW'(speed_q);
                        end
                    end
                    if (cool_q != 8'd0) begin
                        cool_n = cool_q - 8'd1;
                    end else if (lfsr_q[1:0] == 2'd0) begin
                        cool_n = reload;
                    end else if (free_any) begin
                        // Free slot is judged on pre-tick valid, so a slot
                        // retiring now is not reused until the next tick.
                        for (int i = 0; i < NSLOT; i++) begin
                            if (IW'(i) == free_idx) begin
                                valid_n[i] = 1'b1;
                                x_n[i]     = CORDW'(X_SPAWN);
                                lane_n[i]  = lfsr_q[1:0];
                            end
                        end
                        cool_n = reload;
                        if (cnt_q == 8'(SPEEDUP_EVERY - 1)) begin
                            cnt_n = '0;
                            if (speed_q < 4'(MAX_SPEED))
                                speed_n = speed_q + 4'd1;
                        end else begin
                            cnt_n = cnt_q + 8'd1;
                        end
                    end
                end
            end
            HALT: begin
                if (!run || restart) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                x_q[i]    <= '0;
                lane_q[i] <= '0;
            end
            speed_q <= 4'(SPEED0);
            cool_q  <= 8'(MIN_GAP);
            cnt_q   <= '0;
            lfsr_q  <= 16'hACE1;
        end else begin
            state_q <= state_n;
            valid_q <= valid_n;
            x_q     <= x_n;
            lane_q  <= lane_n;
            speed_q <= speed_n;
            cool_q  <= cool_n;
            cnt_q   <= cnt_n;
            lfsr_q  <= lfsr_n;
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_pack
        assign obs_x[g*CORDW +: CORDW] = x_q[g];
        assign obs_lane[2*g +: 2]      = lane_q[g];
    end

    assign obs_valid   = valid_q;
    assign speed       = speed_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: vector table, directed
// corner sequences and random stimulus against a game-level model.
module tb_obstacle_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        tick, run, collide, restart;
    logic [3:0]  obs_valid;
    logic [39:0] obs_x;
    logic [7:0]  obs_lane;
    logic [3:0]  speed;
    logic [1:0]  sched_state;

    int checks = 0;
    int errors = 0;

    obstacle_scheduler dut (
        .Clk(Clk), .Reset(Reset), .tick(tick), .run(run),
        .collide(collide), .restart(restart),
        .obs_valid(obs_valid), .obs_x(obs_x), .obs_lane(obs_lane),
        .speed(speed), .sched_state(sched_state)
    );

    always #5 Clk = ~Clk;

    // Game-level model: integer positions, "mode" as 0 idle/1 run/2 halt.
    int          m_mode;
    bit          m_on   [4];
    int          m_x    [4];
    int          m_lane [4];
    int          m_speed, m_wait, m_since_up, m_total;
    logic [15:0] m_rng;

    function automatic logic [15:0] rng_next(input logic [15:0] r);
        return {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
    endfunction

    task automatic m_reset();
        m_mode = 0;
        foreach (m_on[i]) begin
            m_on[i] = 0; m_x[i] = 0; m_lane[i] = 0;
        end
        m_speed = 2; m_wait = 40; m_since_up = 0; m_total = 0;
        m_rng = 16'hACE1;
    endtask

    task automatic m_step(input bit tk, input bit rn, input bit co,
                          input bit rs);
        int  lane, gap, slot;
        bit  was_free [4];
        if (m_mode == 0) begin
            foreach (m_on[i]) begin
                m_on[i] = 0; m_x[i] = 0; m_lane[i] = 0;
            end
            m_speed = 2; m_wait = 40; m_since_up = 0;
            if (rn) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!rn) m_mode = 0;
            else if (co) m_mode = 2;
            else if (tk) begin
                lane = int'(m_rng[1:0]);
                gap  = 40 + (int'(m_rng[9:2]) % 64);
                foreach (m_on[i]) was_free[i] = !m_on[i];
                foreach (m_on[i])
                    if (m_on[i]) begin
                        if (m_x[i] - m_speed < 170) m_on[i] = 0;
                        else m_x[i] = m_x[i] - m_speed;
                    end
                if (m_wait > 0) m_wait--;
                else if (lane == 0) m_wait = gap;
                else begin
                    slot = -1;
                    for (int i = 3; i >= 0; i--) if (was_free[i]) slot = i;
                    if (slot >= 0) begin
                        m_on[slot] = 1; m_x[slot] = 750; m_lane[slot] = lane;
                        m_wait = gap;
                        m_total++;
                        m_since_up++;
                        if (m_since_up == 8) begin
                            m_since_up = 0;
                            if (m_speed < 8) m_speed++;
                        end
                    end
                end
                m_rng = rng_next(m_rng);
            end
        end else begin
            if (!rn || rs) m_mode = 0;
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [3:0]  ev;
        logic [39:0] ex;
        logic [7:0]  el;
        for (int i = 0; i < 4; i++) begin
            ev[i]          = m_on[i];
            ex[i*10 +: 10] = 10'(m_x[i]);
            el[i*2 +: 2]   = 2'(m_lane[i]);
        end
        cmp("valid", 64'(obs_valid), 64'(ev));
        cmp("x", 64'(obs_x), 64'(ex));
        cmp("lane", 64'(obs_lane), 64'(el));
        cmp("speed", 64'(speed), 64'(m_speed));
        cmp("state", 64'(sched_state), 64'(m_mode));
    endtask

    task automatic step(input bit tk, input bit rn, input bit co,
                        input bit rs);
        tick = tk; run = rn; collide = co; restart = rs;
        m_step(tk, rn, co, rs);
        @(posedge Clk);
        #1;
        cmp_model();
    endtask

    typedef struct {
        bit       tk, rn, co, rs;
        bit [1:0] exp_state;
    } vec_t;

    vec_t        vecs [13];
    logic [39:0] saved_x;
    logic [1:0]  exp_lane;
    bit          seen8;
    int          budget;

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 2'd0};
        vecs[1]  = '{0, 0, 0, 1, 2'd0};
        vecs[2]  = '{1, 1, 0, 0, 2'd1};
        vecs[3]  = '{0, 1, 0, 1, 2'd1};
        vecs[4]  = '{1, 1, 1, 0, 2'd2};
        vecs[5]  = '{1, 1, 0, 0, 2'd2};
        vecs[6]  = '{0, 1, 1, 0, 2'd2};
        vecs[7]  = '{0, 1, 0, 1, 2'd0};
        vecs[8]  = '{0, 1, 0, 0, 2'd1};
        vecs[9]  = '{1, 0, 0, 0, 2'd0};
        vecs[10] = '{0, 1, 0, 0, 2'd1};
        vecs[11] = '{1, 1, 1, 0, 2'd2};
        vecs[12] = '{0, 0, 0, 0, 2'd0};

        Reset = 1'b1; tick = 0; run = 0; collide = 0; restart = 0;
        m_reset();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        cmp("rst_valid", 64'(obs_valid), 64'd0);
        cmp("rst_x", 64'(obs_x), 64'd0);
        cmp("rst_lane", 64'(obs_lane), 64'd0);
        cmp("rst_speed", 64'(speed), 64'd2);
        cmp("rst_state", 64'(sched_state), 64'd0);

        foreach (vecs[i]) begin
            step(vecs[i].tk, vecs[i].rn, vecs[i].co, vecs[i].rs);
            cmp("vec_state", 64'(sched_state), 64'(vecs[i].exp_state));
            cmp("vec_valid", 64'(obs_valid), 64'd0);
            cmp("vec_speed", 64'(speed), 64'd2);
        end

        // First spawn attempt lands on tick 41 after entering RUN.
        Reset = 1'b1; #1 Reset = 1'b0;
        m_reset();
        step(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0, 0);
            if (i % 3 == 0) step(0, 1, 0, 0);
        end
        cmp("t40_valid", 64'(obs_valid), 64'd0);
        exp_lane = m_rng[1:0];
        step(1, 1, 0, 0);
        if (exp_lane != 2'd0) begin
            cmp("t41_valid", 64'(obs_valid), 64'd1);
            cmp("t41_x", 64'(obs_x[9:0]), 64'd750);
            cmp("t41_lane", 64'(obs_lane[1:0]), 64'(exp_lane));
        end else begin
            cmp("t41_novalid", 64'(obs_valid), 64'd0);
        end

        // Long run: retirement boundary, full-slot deferral, speed-up.
        seen8 = 0;
        budget = 0;
        while (m_total < 48 && budget < 30000) begin
            step(($urandom % 4) != 0, 1, 0, 0);
            budget++;
            if (!seen8 && m_total == 8) begin
                seen8 = 1;
                cmp("speed_at8", 64'(speed), 64'd3);
            end
        end
        if (m_total < 48) begin
            errors++;
            $display("FAIL spawn_budget spawns=%0d required=48", m_total);
        end else begin
            cmp("speed_sat", 64'(speed), 64'd8);
        end

        // Collide beats a coincident tick; HALT freezes everything.
        step(0, 1, 0, 0);
        saved_x = obs_x;
        step(1, 1, 1, 0);
        cmp("halt_state", 64'(sched_state), 64'd2);
        cmp("halt_x", 64'(obs_x), 64'(saved_x));
        repeat (5) step(1, 1, 0, 0);
        cmp("halt_frozen", 64'(obs_x), 64'(saved_x));
        step(0, 1, 0, 1);
        cmp("restart_idle", 64'(sched_state), 64'd0);
        step(0, 1, 0, 0);
        cmp("restart_clear", 64'(obs_valid), 64'd0);

        for (int i = 0; i < 3000; i++)
            step($urandom % 2, ($urandom % 300) != 0,
                 ($urandom % 250) == 0, ($urandom % 10) == 0);

        // Asynchronous reset mid-RUN, observed before the next edge.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (200) step(1, 1, 0, 0);
        #2 Reset = 1'b1;
        #1;
        cmp("arst_valid", 64'(obs_valid), 64'd0);
        cmp("arst_x", 64'(obs_x), 64'd0);
        cmp("arst_speed", 64'(speed), 64'd2);
        cmp("arst_state", 64'(sched_state), 64'd0);
        m_reset();
        #1 Reset = 1'b0;
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
